// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine controller and its change dispenser:
// dispenser state encoding, coin codes/values and controller prices.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StIssue,
        StDone,
        StFault
    } disp_state_t;

    localparam logic [1:0] COIN_5 = 2'b10;
    localparam logic [1:0] COIN_2 = 2'b01;
    localparam logic [1:0] COIN_1 = 2'b00;

    localparam int unsigned COIN_5_VAL = 5;
    localparam int unsigned COIN_2_VAL = 2;
    localparam int unsigned COIN_1_VAL = 1;

    localparam int unsigned PRICE_0 = 7;
    localparam int unsigned PRICE_1 = 5;
    localparam int unsigned PRICE_2 = 2;
    localparam int unsigned PRICE_3 = 10;

    function automatic int unsigned coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return COIN_5_VAL;
            COIN_2:  return COIN_2_VAL;
            COIN_1:  return COIN_1_VAL;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin not exceeding the amount owed whose tube is not empty.
module coin_select
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [2:0]       tube_empty,
    output logic             sel_valid,
    output logic [1:0]       sel_type,
    output logic [AMT_W-1:0] sel_value
);

    always_comb begin
        sel_valid = 1'b1;
        sel_type  = COIN_1;
        sel_value = AMT_W'(COIN_1_VAL);
        if (remaining >= AMT_W'(COIN_5_VAL) && !tube_empty[2]) begin
            sel_type  = COIN_5;
            sel_value = AMT_W'(COIN_5_VAL);
        end else if (remaining >= AMT_W'(COIN_2_VAL) && !tube_empty[1]) begin
            sel_type  = COIN_2;
            sel_value = AMT_W'(COIN_2_VAL);
        end else if (tube_empty[0]) begin
            sel_valid = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out captured change one coin at a time over a valid/ready handshake.
// Per-type coin tallies are built only when CHANGE_DISP_TALLY_EN is defined.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             vend_done,
    input  logic [AMT_W-1:0] change_in,
    input  logic [2:0]       tube_empty,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] cnt5,
    output logic [AMT_W-1:0] cnt2,
    output logic [AMT_W-1:0] cnt1
);

    disp_state_t      state;
    logic             vend_q;
    logic             vend_armed;
    logic [AMT_W-1:0] issue_value;
    logic             sel_valid;
    logic [1:0]       sel_type;
    logic [AMT_W-1:0] sel_value;
    logic             start;
    logic             handshake;

    coin_select #(
        .AMT_W(AMT_W)
    ) u_coin_select (
        .remaining (remaining),
        .tube_empty(tube_empty),
        .sel_valid (sel_valid),
        .sel_type  (sel_type),
        .sel_value (sel_value)
    );

    // vend_armed blocks a start from a vend_done level that was already high across clr.
    assign start     = (state == StIdle) && vend_done && !vend_q && vend_armed;
    assign handshake = coin_valid && coin_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= StIdle;
            vend_q      <= 1'b0;
            vend_armed  <= ~vend_done;
            coin_valid  <= 1'b0;
            coin_type   <= COIN_1;
            remaining   <= '0;
            issue_value <= '0;
        end else begin
            vend_q <= vend_done;
            if (!vend_done) begin
                vend_armed <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        remaining <= change_in;
                        state     <= StSel;
                    end
                end
                StSel: begin
                    if (remaining == '0) begin
                        state <= StDone;
                    end else if (sel_valid) begin
                        coin_type   <= sel_type;
                        issue_value <= sel_value;
                        coin_valid  <= 1'b1;
                        state       <= StIssue;
                    end else begin
                        state <= StFault;
                    end
                end
                StIssue: begin
                    if (handshake) begin
                        remaining  <= remaining - issue_value;
                        coin_valid <= 1'b0;
                        state      <= StSel;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                StFault: begin
                    coin_valid <= 1'b0;
                end
                default: begin
                    state      <= StIdle;
                    coin_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (state == StSel) || (state == StIssue) || (state == StDone);
    assign done  = (state == StDone);
    assign fault = (state == StFault);

`ifdef CHANGE_DISP_TALLY_EN
    always_ff @(posedge clk) begin
        if (clr || start) begin
            cnt5 <= '0;
            cnt2 <= '0;
            cnt1 <= '0;
        end else if (state == StIssue && handshake) begin
            case (coin_type)
                COIN_5:  if (cnt5 != '1) cnt5 <= cnt5 + AMT_W'(1);
                COIN_2:  if (cnt2 != '1) cnt2 <= cnt2 + AMT_W'(1);
                default: if (cnt1 != '1) cnt1 <= cnt1 + AMT_W'(1);
            endcase
        end
    end
`else
    assign cnt5 = '0;
    assign cnt2 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed payouts checked against a greedy change model.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int unsigned AMT_W = 4;
`ifdef CHANGE_DISP_TALLY_EN
    localparam bit TALLY = 1'b1;
`else
    localparam bit TALLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr;
    logic             vend_done;
    logic [AMT_W-1:0] change_in;
    logic [2:0]       tube_empty;
    logic             coin_ready;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] cnt5;
    logic [AMT_W-1:0] cnt2;
    logic [AMT_W-1:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    int exp_q[$];
    bit exp_fault;
    int exp_rem;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W(AMT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .vend_done (vend_done),
        .change_in (change_in),
        .tube_empty(tube_empty),
        .coin_ready(coin_ready),
        .coin_valid(coin_valid),
        .coin_type (coin_type),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .remaining (remaining),
        .cnt5      (cnt5),
        .cnt2      (cnt2),
        .cnt1      (cnt1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int type_to_value(input logic [1:0] t);
        case (t)
            2'b10:   return 5;
            2'b01:   return 2;
            2'b00:   return 1;
            default: return 99;
        endcase
    endfunction

    // Greedy change-making with empty tubes skipped.
    task automatic model(input int amt, input logic [2:0] te);
        int rem;
        rem = amt;
        exp_q.delete();
        exp_fault = 1'b0;
        while (rem > 0) begin
            if (rem >= 5 && !te[2]) begin
                exp_q.push_back(5);
                rem -= 5;
            end else if (rem >= 2 && !te[1]) begin
                exp_q.push_back(2);
                rem -= 2;
            end else if (!te[0]) begin
                exp_q.push_back(1);
                rem -= 1;
            end else begin
                exp_fault = 1'b1;
                break;
            end
        end
        exp_rem = rem;
    endtask

    task automatic do_reset();
        clr        = 1'b1;
        vend_done  = 1'b0;
        coin_ready = 1'b0;
        change_in  = '0;
        tube_empty = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check_eq({name, "_valid"}, coin_valid, 0);
        check_eq({name, "_type"}, coin_type, 0);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_done"}, done, 0);
        check_eq({name, "_fault"}, fault, 0);
        check_eq({name, "_rem"}, remaining, 0);
        check_eq({name, "_cnt"}, cnt5 + cnt2 + cnt1, 0);
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low for the first 4 offered cycles
    task automatic run_payout(input int amt, input logic [2:0] te, input int mode,
                              input string name);
        int got_q[$];
        int done_j;
        int first_v;
        int stall_seen;
        int n5;
        int n2;
        int n1;
        bit unstable;
        bit rem_moved;
        bit flt_seen;
        bit pend;
        logic [1:0] held;
        done_j = -1;
        first_v = -1;
        stall_seen = 0;
        unstable = 1'b0;
        rem_moved = 1'b0;
        flt_seen = 1'b0;
        pend = 1'b0;
        held = 2'b00;
        model(amt, te);
        @(negedge clk);
        change_in  = AMT_W'(amt);
        tube_empty = te;
        vend_done  = 1'b1;
        coin_ready = (mode != 2);
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check_eq({name, "_busy_n1"}, busy, 1);
                vend_done = 1'b0;
                change_in = AMT_W'($urandom);
            end
            if (done) begin
                done_j = j;
                check_eq({name, "_busy_at_done"}, busy, 1);
                break;
            end
            if (fault) begin
                flt_seen = 1'b1;
                break;
            end
            if (coin_valid) begin
                if (first_v < 0) first_v = j;
                if (pend && coin_type != held) unstable = 1'b1;
                held = coin_type;
            end
            case (mode)
                0:       coin_ready = 1'b1;
                1:       coin_ready = 1'($urandom_range(0, 1));
                default: coin_ready = (stall_seen >= 4);
            endcase
            if (mode == 2 && coin_valid && stall_seen < 4) begin
                stall_seen++;
                if (remaining != AMT_W'(amt)) rem_moved = 1'b1;
            end
            if (coin_valid && coin_ready) begin
                got_q.push_back(type_to_value(coin_type));
                pend = 1'b0;
            end else begin
                pend = coin_valid;
            end
        end
        if (done_j < 0 && !flt_seen) begin
            check_eq({name, "_timeout"}, 1, 0);
        end
        check_eq({name, "_fault"}, flt_seen, exp_fault);
        check_eq({name, "_ncoins"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_coin%0d", name, i), got_q[i], exp_q[i]);
        end
        check_eq({name, "_rem"}, remaining, exp_rem);
        check_eq({name, "_stable"}, unstable, 0);
        n5 = 0;
        n2 = 0;
        n1 = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i] == 5) n5++;
            else if (exp_q[i] == 2) n2++;
            else n1++;
        end
        check_eq({name, "_cnt5"}, cnt5, TALLY ? n5 : 0);
        check_eq({name, "_cnt2"}, cnt2, TALLY ? n2 : 0);
        check_eq({name, "_cnt1"}, cnt1, TALLY ? n1 : 0);
        if (mode == 0 && !exp_fault) begin
            check_eq({name, "_done_cycle"}, done_j, 2 + 2 * exp_q.size());
            if (exp_q.size() > 0) check_eq({name, "_first_valid"}, first_v, 2);
        end
        if (mode == 2) check_eq({name, "_rem_held"}, rem_moved, 0);
        if (done_j > 0) begin
            @(negedge clk);
            check_eq({name, "_done_pulse"}, done, 0);
            check_eq({name, "_busy_after"}, busy, 0);
        end
        if (flt_seen) begin
            check_eq({name, "_fault_valid"}, coin_valid, 0);
            check_eq({name, "_fault_busy"}, busy, 0);
            repeat (3) @(negedge clk);
            check_eq({name, "_fault_sticky"}, fault, 1);
            check_eq({name, "_fault_rem"}, remaining, exp_rem);
        end
    endtask

    initial begin
        bit retrig;
        do_reset();
        check_reset_values("reset");

        run_payout(8, 3'b000, 0, "c8");
        run_payout(0, 3'b000, 0, "c0");
        run_payout(7, 3'b100, 0, "c7");
        run_payout(6, 3'b011, 0, "c6");
        do_reset();
        check_eq("c6_fault_cleared", fault, 0);
        run_payout(5, 3'b000, 2, "c5");
        run_payout(15, 3'b000, 0, "c15");

        // Abort a 15 payout in ISSUE while vend_done stays high.
        @(negedge clk);
        change_in  = 4'd15;
        tube_empty = 3'b000;
        coin_ready = 1'b0;
        vend_done  = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_valid", coin_valid, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_reset_values("mid_clr");
        coin_ready = 1'b1;
        retrig = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy) retrig = 1'b1;
        end
        check_eq("mid_no_retrigger", retrig, 0);
        vend_done = 1'b0;
        run_payout(15, 3'b000, 0, "after_clr");

        for (int k = 0; k < 24; k++) begin
            int amt;
            logic [2:0] te;
            amt = $urandom_range(0, 15);
            te  = 3'($urandom_range(0, 7));
            run_payout(amt, te, 1, $sformatf("rnd%0d", k));
            if (fault) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
